// File: rtl/pipe_reg_chain.sv
// Elastic register chain: DEPTH stages of WIDTH-bit data, with a valid/ready
// handshake on both ends, a synchronous flush and an occupancy count.
// Bubbles are squeezed out under back-pressure, and full-rate streaming is
// sustained even when every stage is full.
module pipe_reg_chain #(
  parameter int unsigned       WIDTH     = 32,
  parameter int unsigned       DEPTH     = 2,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [WIDTH-1:0]           in_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [WIDTH-1:0]           out_data_o,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] d_q  [DEPTH];
  logic [WIDTH-1:0] d_d  [DEPTH];
  // rdy[i]: stage i can take a word this cycle; rdy[DEPTH] is the downstream ready
  logic [DEPTH:0]   rdy;
  // Upstream offer into each stage: the chain input for stage 0, else the previous stage
  logic [DEPTH-1:0] up_v;
  logic [WIDTH-1:0] up_d [DEPTH];
  logic [CntW-1:0]  cnt;

  // Ready ripples back from the output: a stage is ready if empty or if it can drain
  always_comb begin
    logic run;
    rdy        = '0;
    run        = out_ready_i;
    rdy[DEPTH] = out_ready_i;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      run    = ~v_q[i] | run;
      rdy[i] = run;
    end
  end

  assign in_ready_o = rdy[0] & ~flush_i;

  // Source of each stage's incoming transfer
  always_comb begin
    up_v    = '0;
    up_v[0] = in_valid_i & in_ready_o;
    up_d[0] = in_data_i;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      up_v[i] = v_q[i-1];
      up_d[i] = d_q[i-1];
    end
  end

  // Next-state: receive when offered and ready; otherwise a valid stage stays valid
  // only if it cannot send. Flush clears every valid and blocks every transfer.
  always_comb begin
    v_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      d_d[i] = d_q[i];
      if (!flush_i) begin
        v_d[i] = (up_v[i] & rdy[i]) | (v_q[i] & ~rdy[i+1]);
        if (up_v[i] && rdy[i]) begin
          d_d[i] = up_d[i];
        end
      end
    end
  end

  // State registers with synchronous reset; reset wins over flush and transfers
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        d_q[i] <= RESET_VAL;
      end
    end else begin
      v_q <= v_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        d_q[i] <= d_d[i];
      end
    end
  end

  // Occupancy is the number of valid stages
  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      cnt = cnt + CntW'(v_q[i]);
    end
  end

  assign occupancy_o = cnt;
  assign out_valid_o = v_q[DEPTH-1];
  assign out_data_o  = d_q[DEPTH-1];

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain: a DEPTH=2 instance for directed cases and a DEPTH=4
// instance for a long random handshake run. Stimulus pushes expected words into
// per-instance queues; monitors pop and compare whenever a word leaves the DUT.
module tb_pipe_reg_chain;

  typedef struct packed {
    int unsigned ts;
    logic [31:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // DEPTH=2 instance
  logic        fl2 = 0, iv2 = 0, or2 = 0, ir2, ov2;
  logic [31:0] id2 = '0, od2;
  logic [1:0]  occ2;
  logic        lat = 0;
  ent_t        q2[$];

  pipe_reg_chain #(.WIDTH(32), .DEPTH(2), .RESET_VAL(32'hDEADBEEF)) dut2 (
    .clk(clk), .reset(rst), .flush_i(fl2), .in_valid_i(iv2), .in_ready_o(ir2),
    .in_data_i(id2), .out_valid_o(ov2), .out_ready_i(or2), .out_data_o(od2),
    .occupancy_o(occ2)
  );

  // DEPTH=4 instance
  logic        fl4 = 0, iv4 = 0, or4 = 0, ir4, ov4;
  logic [15:0] id4 = '0, od4;
  logic [2:0]  occ4;
  ent_t        q4[$];

  pipe_reg_chain #(.WIDTH(16), .DEPTH(4), .RESET_VAL(16'h0)) dut4 (
    .clk(clk), .reset(rst), .flush_i(fl4), .in_valid_i(iv4), .in_ready_o(ir4),
    .in_data_i(id4), .out_valid_o(ov4), .out_ready_i(or4), .out_data_o(od4),
    .occupancy_o(occ4)
  );

  // Monitor for the DEPTH=2 chain; inputs are stable at negedge
  always @(negedge clk) begin
    bit   er;
    ent_t e;
    if (rst) begin
      q2.delete();
    end else begin
      er = !fl2 && (q2.size() < 2 || or2);
      chk("occupancy2", occ2, q2.size());
      chk("in_ready2", ir2, er);
      if (!fl2 && ov2 && or2) begin
        if (q2.size() == 0) begin
          chk("spurious_out2", ov2, 0);
        end else begin
          e = q2.pop_front();
          chk("data2", od2, e.d);
          if (lat) chk("latency2", cyc - e.ts, 2);
        end
      end
      if (fl2) q2.delete();
      else if (iv2 && er) q2.push_back('{ts: cyc, d: id2});
    end
  end

  // Monitor for the DEPTH=4 chain
  always @(negedge clk) begin
    bit   er;
    ent_t e;
    if (rst) begin
      q4.delete();
    end else begin
      er = !fl4 && (q4.size() < 4 || or4);
      chk("occupancy4", occ4, q4.size());
      chk("in_ready4", ir4, er);
      if (!fl4 && ov4 && or4) begin
        if (q4.size() == 0) begin
          chk("spurious_out4", ov4, 0);
        end else begin
          e = q4.pop_front();
          chk("data4", od4, e.d);
        end
      end
      if (fl4) q4.delete();
      else if (iv4 && er) q4.push_back('{ts: cyc, d: {16'h0, id4}});
    end
  end

  // Apply one cycle of inputs to the DEPTH=2 chain; called at posedge+1
  task automatic drive2(input logic v, input logic [31:0] d, input logic ordy, input logic f);
    iv2 = v; id2 = d; or2 = ordy; fl2 = f;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", ov2, 0);
    chk("reset_out_data", od2, 32'hDEADBEEF);
    chk("reset_occupancy", occ2, 0);
    chk("reset_in_ready", ir2, 1);
    @(posedge clk); #1;

    // Streaming at full rate, latency 2
    lat = 1'b1;
    for (int k = 1; k <= 8; k++) drive2(1'b1, 32'(k), 1'b1, 1'b0);
    repeat (3) drive2(1'b0, '0, 1'b1, 1'b0);
    lat = 1'b0;
    chk("stream_drained", q2.size(), 0);

    // Back-pressure: A and B fill the chain, C held
    drive2(1'b1, 32'hA, 1'b0, 1'b0);
    drive2(1'b1, 32'hB, 1'b0, 1'b0);
    iv2 = 1'b1; id2 = 32'hC; or2 = 1'b0;
    @(negedge clk);
    chk("bp_full_in_ready", ir2, 0);
    chk("bp_full_occ", occ2, 2);
    chk("bp_full_out_data", od2, 32'hA);
    @(posedge clk); #1;
    // One cycle of out_ready: pop A and accept C on the same edge
    or2 = 1'b1;
    @(negedge clk);
    chk("bp_pushpop_in_ready", ir2, 1);
    @(posedge clk); #1;
    or2 = 1'b0; iv2 = 1'b0;
    @(negedge clk);
    chk("bp_after_occ", occ2, 2);
    chk("bp_after_out_data", od2, 32'hB);
    @(posedge clk); #1;
    repeat (3) drive2(1'b0, '0, 1'b1, 1'b0);
    chk("bp_drained", q2.size(), 0);

    // Flush a full chain while offering a word
    drive2(1'b1, 32'h11, 1'b0, 1'b0);
    drive2(1'b1, 32'h22, 1'b0, 1'b0);
    iv2 = 1'b1; id2 = 32'h33; or2 = 1'b1; fl2 = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", ir2, 0);
    @(posedge clk); #1;
    iv2 = 1'b0; or2 = 1'b0; fl2 = 1'b0;
    @(negedge clk);
    chk("flush_occ", occ2, 0);
    chk("flush_out_valid", ov2, 0);
    chk("flush_data_kept", od2, 32'h11);
    @(posedge clk); #1;

    // Reset together with flush and a pending input
    drive2(1'b1, 32'h55, 1'b0, 1'b0);
    drive2(1'b1, 32'h66, 1'b0, 1'b0);
    rst = 1'b1; fl2 = 1'b1; iv2 = 1'b1; id2 = 32'h77;
    @(posedge clk); #1;
    rst = 1'b0; fl2 = 1'b0; iv2 = 1'b0;
    @(negedge clk);
    chk("rstflush_out_valid", ov2, 0);
    chk("rstflush_out_data", od2, 32'hDEADBEEF);
    chk("rstflush_occ", occ2, 0);
    @(posedge clk); #1;

    // DEPTH=4 random handshake run with occasional flush
    for (int k = 0; k < 10000; k++) begin
      iv4 = 1'($urandom_range(0, 1));
      id4 = 16'($urandom);
      or4 = ($urandom_range(0, 3) != 0);
      fl4 = ($urandom_range(0, 63) == 0);
      @(posedge clk); #1;
    end
    iv4 = 1'b0; fl4 = 1'b0; or4 = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rand_drained", q4.size(), 0);
    chk("rand_final_occ", occ4, 0);

    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
